// File: rtl/aucohl_pwm_capture.sv
// PWM capture: measures the period and active time of an asynchronous input in prescaled ticks.
// Optional 3-sample glitch filter behind the synchronizer: define AUCOHL_PWMCAP_FILTER_EN.
module aucohl_pwm_capture #(
  parameter int PRW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           polarity,
  input  logic           oneshot,
  input  logic [PRW-1:0] prescaler,
  input  logic           pwm_in,
  output logic [31:0]    period,
  output logic [31:0]    active_time,
  output logic           done,
  output logic           busy,
  output logic           ovf
);

  typedef enum logic [2:0] {IDLE, ARM, ACTIVE, INACTIVE, HOLD} state_e;

  state_e         state_q, state_d;
  logic           s1_q, s2_q;
  logic           sig_cur, sig_prev;
  logic           rise, fall, start_edge, stop_edge;
  logic [PRW-1:0] pre_q, pre_d;
  logic           tick;
  logic [31:0]    cnt_q, cnt_d, pcnt_q, pcnt_d;
  logic [32:0]    cnt_inc, pcnt_inc;
  logic [31:0]    period_q, period_d, active_q, active_d;
  logic           done_q, done_d, ovf_q, ovf_d;

`ifdef AUCOHL_PWMCAP_FILTER_EN
  logic h1_q, h2_q, filt_q, filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      h1_q   <= s2_q;
      h2_q   <= h1_q;
      filt_q <= filt_d;
    end
  end

  // Filtered level follows the synchronizer only once three consecutive samples agree.
  always_comb begin
    filt_d = filt_q;
    if ((s2_q == h1_q) && (h1_q == h2_q)) filt_d = s2_q;
  end

  assign sig_cur  = filt_d;
  assign sig_prev = filt_q;
`else
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sig_cur  = s2_q;
  assign sig_prev = s3_q;
`endif

  assign rise       = sig_cur & ~sig_prev;
  assign fall       = ~sig_cur & sig_prev;
  assign start_edge = polarity ? fall : rise;
  assign stop_edge  = polarity ? rise : fall;

  // Prescaler restarts on every start edge so tick phase is aligned to the measured signal.
  assign tick = (pre_q == '0);

  always_comb begin
    pre_d = pre_q - PRW'(1);
    if (!en || start_edge || tick) pre_d = prescaler;
  end

  assign cnt_inc  = {1'b0, cnt_q}  + 33'(tick);
  assign pcnt_inc = {1'b0, pcnt_q} + 33'(tick);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    active_d = active_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: if (en) state_d = ARM;
      ARM: begin
        if (start_edge) begin
          cnt_d   = '0;
          pcnt_d  = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE, INACTIVE: begin
        if (cnt_inc[32] || pcnt_inc[32]) begin
          // Saturated counter: drop this measurement and wait for a fresh start edge.
          cnt_d   = cnt_inc[32]  ? '1 : cnt_inc[31:0];
          pcnt_d  = pcnt_inc[32] ? '1 : pcnt_inc[31:0];
          ovf_d   = 1'b1;
          state_d = ARM;
        end else if ((state_q == ACTIVE) && stop_edge) begin
          active_d = cnt_inc[31:0];
          cnt_d    = '0;
          pcnt_d   = pcnt_inc[31:0];
          state_d  = INACTIVE;
        end else if ((state_q == INACTIVE) && start_edge) begin
          period_d = pcnt_inc[31:0];
          done_d   = 1'b1;
          cnt_d    = '0;
          pcnt_d   = '0;
          state_d  = oneshot ? HOLD : ACTIVE;
        end else begin
          cnt_d  = cnt_inc[31:0];
          pcnt_d = pcnt_inc[31:0];
        end
      end
      HOLD:    state_d = HOLD;
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      active_q <= active_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period      = period_q;
  assign active_time = active_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q == ARM) || (state_q == ACTIVE) || (state_q == INACTIVE);

endmodule

// File: tb/tb_aucohl_pwm_capture.sv
// Self-checking bench for aucohl_pwm_capture; expected tick counts come from floor(clocks / (prescaler+1)).
`timescale 1ns/1ps
module tb_aucohl_pwm_capture;

  localparam int PRW = 16;
`ifdef AUCOHL_PWMCAP_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n, en, polarity, oneshot, pwm_in;
  logic [PRW-1:0] prescaler;
  logic [31:0]    period, active_time;
  logic           done, busy, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation of the done pulse stream, sampled on the falling edge.
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;
  logic [31:0] last_per = '0;
  logic [31:0] last_act = '0;

  aucohl_pwm_capture #(.PRW(PRW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .polarity    (polarity),
    .oneshot     (oneshot),
    .prescaler   (prescaler),
    .pwm_in      (pwm_in),
    .period      (period),
    .active_time (active_time),
    .done        (done),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      last_per      = period;
      last_act      = active_time;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ticks(input int clks, input int p);
    return clks / (p + 1);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_for(input logic lvl, input int n);
    pwm_in = lvl;
    step(n);
  endtask

  // Drop en, load the configuration with the input at its inactive level, then re-enable.
  task automatic restart(input int p, input logic pol, input logic os);
    en        = 1'b0;
    polarity  = pol;
    oneshot   = os;
    prescaler = PRW'(p);
    pwm_in    = pol;
    step(8);
    en = 1'b1;
    step(3);
  endtask

  // reps full periods, then one more start edge so the last period is reported.
  task automatic run_train(input logic act_lvl, input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      pwm_for(act_lvl, h);
      pwm_for(~act_lvl, l);
    end
    pwm_for(act_lvl, LAT + 3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; polarity = 1'b0; oneshot = 1'b0; prescaler = '0; pwm_in = 1'b0;
    step(3);
    n_cmp++; if (period !== 32'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
    n_cmp++; if (active_time !== 32'd0) begin n_bad++; $display("FAIL reset_active: got %0d want 0", active_time); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    int d0, lat;
    restart(0, 1'b0, 1'b0);
    d0 = done_cnt;
    for (int r = 0; r < 4; r++) begin
      pwm_for(1'b1, 10);
      pwm_for(1'b0, 30);
    end
    pwm_in = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      step(1);
      lat++;
    end
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL basic_latency: got %0d clk want %0d", lat, LAT); end
    step(1);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done); end
    n_cmp++; if (done_cnt - d0 != 4) begin n_bad++; $display("FAIL basic_done_count: got %0d want 4", done_cnt - d0); end
    n_cmp++; if (last_act !== 32'd10) begin n_bad++; $display("FAIL basic_active: got %0d want 10", last_act); end
    n_cmp++; if (last_per !== 32'd40) begin n_bad++; $display("FAIL basic_period: got %0d want 40", last_per); end
    n_cmp++; if (last_done_cyc - prev_done_cyc != 40) begin n_bad++; $display("FAIL basic_done_gap: got %0d want 40", last_done_cyc - prev_done_cyc); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_prescaler();
    int d0;
    restart(3, 1'b0, 1'b0);
    d0 = done_cnt;
    run_train(1'b1, 10, 30, 3);
    n_cmp++; if (done_cnt - d0 != 3) begin n_bad++; $display("FAIL presc_done_count: got %0d want 3", done_cnt - d0); end
    n_cmp++; if (last_act !== 32'd2) begin n_bad++; $display("FAIL presc_active: got %0d want 2", last_act); end
    n_cmp++; if (last_per !== 32'd10) begin n_bad++; $display("FAIL presc_period: got %0d want 10", last_per); end
  endtask

  task automatic test_random();
    int d0, p, h, l;
    logic pol;
    for (int it = 0; it < 8; it++) begin
      p   = int'($urandom_range(0, 4));
      h   = int'($urandom_range(3, 25));
      l   = int'($urandom_range(3, 25));
      pol = 1'($urandom_range(0, 1));
      restart(p, pol, 1'b0);
      d0 = done_cnt;
      run_train(~pol, h, l, 2);
      n_cmp++; if (done_cnt - d0 != 2) begin n_bad++; $display("FAIL rand%0d_done_count: got %0d want 2", it, done_cnt - d0); end
      n_cmp++; if (last_act !== 32'(ticks(h, p))) begin n_bad++; $display("FAIL rand%0d_active (p=%0d h=%0d l=%0d pol=%0d): got %0d want %0d", it, p, h, l, pol, last_act, ticks(h, p)); end
      n_cmp++; if (last_per !== 32'(ticks(h + l, p))) begin n_bad++; $display("FAIL rand%0d_period (p=%0d h=%0d l=%0d pol=%0d): got %0d want %0d", it, p, h, l, pol, last_per, ticks(h + l, p)); end
    end
  endtask

  task automatic test_oneshot();
    int d0;
    restart(0, 1'b1, 1'b1);
    d0 = done_cnt;
    run_train(1'b0, 7, 13, 3);
    step(5);
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL oneshot_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (last_act !== 32'd7) begin n_bad++; $display("FAIL oneshot_active: got %0d want 7", last_act); end
    n_cmp++; if (last_per !== 32'd20) begin n_bad++; $display("FAIL oneshot_period: got %0d want 20", last_per); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy_hold: got %b want 0", busy); end
  endtask

  task automatic test_en_abort();
    int d0, d1;
    restart(0, 1'b0, 1'b0);
    d0 = done_cnt;
    run_train(1'b1, 10, 30, 1);
    step(2);
    en = 1'b0;
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_next_clk: busy got %b want 0", busy); end
    step(5);
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (period !== 32'd40) begin n_bad++; $display("FAIL abort_period_held: got %0d want 40", period); end
    n_cmp++; if (active_time !== 32'd10) begin n_bad++; $display("FAIL abort_active_held: got %0d want 10", active_time); end
    en = 1'b1;
    step(3);
    d1 = done_cnt;
    pwm_for(1'b0, 14);
    pwm_for(1'b1, 6);
    pwm_for(1'b0, 14);
    n_cmp++; if (done_cnt != d1) begin n_bad++; $display("FAIL rearm_early_done: got %0d want 0", done_cnt - d1); end
    pwm_for(1'b1, LAT + 3);
    n_cmp++; if (done_cnt - d1 != 1) begin n_bad++; $display("FAIL rearm_done_count: got %0d want 1", done_cnt - d1); end
    n_cmp++; if (last_act !== 32'd6) begin n_bad++; $display("FAIL rearm_active: got %0d want 6", last_act); end
    n_cmp++; if (last_per !== 32'd20) begin n_bad++; $display("FAIL rearm_period: got %0d want 20", last_per); end
  endtask

  task automatic test_overflow();
    int d0;
    logic [31:0] per0, act0;
    restart(0, 1'b0, 1'b0);
    d0   = done_cnt;
    per0 = period;
    act0 = active_time;
    pwm_for(1'b1, LAT + 2);
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFF0;
    @(negedge clk);
    release dut.cnt_q;
    step(30);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy_arm: got %b want 1", busy); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL ovf_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (period !== per0) begin n_bad++; $display("FAIL ovf_period_held: got %0d want %0d", period, per0); end
    n_cmp++; if (active_time !== act0) begin n_bad++; $display("FAIL ovf_active_held: got %0d want %0d", active_time, act0); end
    en = 1'b0;
    step(2);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_on_en_low: got %b want 0", ovf); end
  endtask

  task automatic test_glitch();
    int d0;
    restart(0, 1'b0, 1'b0);
    d0 = done_cnt;
    pwm_for(1'b1, 10);
    pwm_for(1'b0, 14);
    pwm_for(1'b1, 2);
    pwm_for(1'b0, 14);
    pwm_for(1'b1, LAT + 3);
    n_cmp++; if (done_cnt - d0 != (FILT ? 1 : 2)) begin n_bad++; $display("FAIL glitch_done_count: got %0d want %0d", done_cnt - d0, FILT ? 1 : 2); end
    n_cmp++; if (last_act !== (FILT ? 32'd10 : 32'd2)) begin n_bad++; $display("FAIL glitch_active: got %0d want %0d", last_act, FILT ? 10 : 2); end
    n_cmp++; if (last_per !== (FILT ? 32'd40 : 32'd16)) begin n_bad++; $display("FAIL glitch_period: got %0d want %0d", last_per, FILT ? 40 : 16); end
  endtask

  task automatic test_reset_mid();
    restart(0, 1'b0, 1'b0);
    run_train(1'b1, 12, 8, 1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (period !== 32'd0) begin n_bad++; $display("FAIL midreset_period: got %0d want 0", period); end
    n_cmp++; if (active_time !== 32'd0) begin n_bad++; $display("FAIL midreset_active: got %0d want 0", active_time); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescaler();
    test_random();
    test_oneshot();
    test_en_abort();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aucohl_pwm_capture.md
AUCOHL_PWM_CAPTURE -- requirements
Module: aucohl_pwm_capture

Interface
REQ-001 SHALL have parameter PRW, default 16, width of prescaler.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  capture enable; low forces IDLE.
REQ-005 SHALL have port polarity  input  1  0: start edge rising, active phase high; 1: start edge falling, active phase low.
REQ-006 SHALL have port oneshot  input  1  1: stop after first completed measurement.
REQ-007 SHALL have port prescaler  input  PRW  tick divider, one tick every prescaler+1 clk.
REQ-008 SHALL have port pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-009 SHALL have port period  output  32  ticks between consecutive start edges.
REQ-010 SHALL have port active_time  output  32  ticks from start edge to opposite edge.
REQ-011 SHALL have port done  output  1  one-clk pulse when period and active_time update together.
REQ-012 SHALL have port busy  output  1  high in states ARM, ACTIVE, INACTIVE.
REQ-013 SHALL have port ovf  output  1  sticky counter-saturation flag.

Function
REQ-014 SHALL synchronize pwm_in through two flops; edges are detected by comparing the second stage with a third, previous-value flop.
REQ-015 SHALL produce a tick when the prescaler down-counter is 0, reloading it with prescaler; the counter reloads to prescaler on every start edge and while en is low.
REQ-016 SHALL implement FSM states IDLE, ARM, ACTIVE, INACTIVE, HOLD.
REQ-017 SHALL transition IDLE->ARM on the cycle after en is sampled high; edges in the en-rise cycle are ignored.
REQ-018 SHALL, in ARM, ignore the input level and wait for a genuine start edge, then go to ACTIVE with cnt <= 0.
REQ-019 SHALL, in ACTIVE and INACTIVE, increment the 32-bit cnt by 1 on every tick.
REQ-020 SHALL, on the opposite edge in ACTIVE, load active_time <= cnt + tick, set cnt <= 0 and go to INACTIVE; period keeps counting in a separate accumulator pcnt.
REQ-021 SHALL, on a start edge in INACTIVE, load period <= pcnt + tick, pulse done for one cycle, and go to ACTIVE (oneshot=0) with cnt and pcnt cleared, or to HOLD (oneshot=1).
REQ-022 SHALL make HOLD exit only via en low (to IDLE).
REQ-023 SHALL, when cnt or pcnt would exceed 32'hFFFFFFFF, saturate, set ovf, discard the measurement without a done pulse, and go to ARM.
REQ-024 SHALL, on en low in any state, go to IDLE on the next clk, clear cnt, pcnt, and ovf, and hold period and active_time at their last values.
REQ-025 SHALL give a latency of 3 clk from a pwm_in transition to the corresponding done or register update.
REQ-026 SHALL read polarity and oneshot continuously; changing them mid-measurement is undefined.

Reset
REQ-027 SHALL, on rst_n low, immediately force: FSM to IDLE; period, active_time, cnt, pcnt to 0; done, busy, and ovf to 0; synchronizer flops to 0; prescaler counter to 0.

Configuration
REQ-028 SHALL, with AUCOHL_PWMCAP_FILTER_EN defined, insert a glitch filter after the synchronizer whose output changes only after 3 consecutive equal samples.
REQ-029 SHALL, with AUCOHL_PWMCAP_FILTER_EN defined, reject pulses shorter than 3 clk and give a total latency of 5 clk.
REQ-030 SHALL, without AUCOHL_PWMCAP_FILTER_EN, omit the filter with no filter logic present and keep the latency at 3 clk.

Verification
REQ-031 SHALL verify: prescaler=0, polarity=0, oneshot=0, pwm_in high 10 clk / low 30 clk repeated -> done every 40 clk, active_time=10, period=40, busy=1.
REQ-032 SHALL verify: prescaler=3, same waveform -> active_time=2, period=10 (up to 1 tick of prescaler phase).
REQ-033 SHALL verify: polarity=1, oneshot=1, pwm_in low 7 / high 13 -> one done with active_time=7, period=20, then HOLD, busy=0, no further done.
REQ-034 SHALL verify: en deasserted mid-ACTIVE -> IDLE next clk, no done, period and active_time unchanged; en reasserted -> first done only after a full new period.
REQ-035 SHALL verify: pwm_in stuck high after the start edge, with a forced near-full cnt preload -> ovf=1, no done, FSM in ARM.
REQ-036 SHALL verify: with AUCOHL_PWMCAP_FILTER_EN, a 2-clk glitch inside the 30-clk low phase -> measurements unchanged (10/40); without it -> spurious shorter period reported.
